axi_slave_aw_stage: RTL and testbench

//  AXI4 slave write-address stage, directly upstream of the slave W-channel stage. Accepts AW

---
 rtl/axi_slave_aw_stage.sv | 162 ++++++++++++++++
 tb/tb_axi_slave_aw_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_aw_stage.sv
// AXI4 slave write-address stage: accepts AW handshakes, flags illegal bursts, queues them
// in a small FIFO and presents the registered head burst to the downstream W-channel stage.
module axi_slave_aw_stage #(
    parameter int DEPTH  = 2,
    parameter int ID_W   = 12,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axi_aresetn,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [ID_W-1:0]            s_axi_awid,
    input  logic [ADDR_W-1:0]          s_axi_awaddr,
    input  logic [7:0]                 s_axi_awlen,
    input  logic [2:0]                 s_axi_awsize,
    input  logic [1:0]                 s_axi_awburst,
    output logic                       tx_wactive,
    output logic [ID_W-1:0]            tx_awid,
    output logic [ADDR_W-1:0]          tx_awaddr,
    output logic [7:0]                 tx_awlen,
    output logic [2:0]                 tx_awsize,
    output logic [1:0]                 tx_awburst,
    output logic                       tx_slverr,
    input  logic                       tx_done,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] BURST_INCR = 2'd1;
    localparam logic [1:0] BURST_WRAP = 2'd2;
    localparam logic [1:0] BURST_RSVD = 2'd3;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_q;
    entry_t          head_next;
    entry_t          incoming;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   remaining;
    logic            srst;
    logic            push;
    logic            pop;
    logic            head_load;

    logic            wrap_len_ok;
    logic            size_aligned;
    logic            crosses_4k;
    logic [13:0]     beats;
    logic [13:0]     span_bytes;
    logic [13:0]     span_end;
    logic            burst_err;

    assign srst = rst | ~s_axi_aresetn;
    assign push = s_axi_awvalid & s_axi_awready;
    assign pop  = tx_done & (count != '0);

    // Legality check on the live AW fields; the verdict travels with the burst as its err bit.
    always_comb begin
        wrap_len_ok  = s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15};
        size_aligned = 1'b0;
        case (s_axi_awsize)
            3'd0:    size_aligned = 1'b1;
            3'd1:    size_aligned = ~s_axi_awaddr[0];
            3'd2:    size_aligned = (s_axi_awaddr[1:0] == 2'b00);
            default: size_aligned = 1'b0;
        endcase
        beats      = {6'b0, s_axi_awlen} + 14'd1;
        span_bytes = beats << s_axi_awsize;
        span_end   = {2'b00, s_axi_awaddr[11:0]} + span_bytes;
        crosses_4k = (span_end > 14'd4096);
        burst_err  = (s_axi_awsize > 3'd2)
                   | (s_axi_awburst == BURST_RSVD)
                   | ((s_axi_awburst == BURST_WRAP) & ~wrap_len_ok)
                   | ((s_axi_awburst == BURST_WRAP) & ~size_aligned)
                   | ((s_axi_awburst == BURST_INCR) & crosses_4k);
    end

    always_comb begin
        incoming       = '0;
        incoming.id    = s_axi_awid;
        incoming.addr  = s_axi_awaddr;
        incoming.len   = s_axi_awlen;
        incoming.size  = s_axi_awsize;
        incoming.burst = s_axi_awburst;
        incoming.err   = burst_err;
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // The head register reloads only when the head leaves or a burst lands in an empty FIFO;
    // a burst pushed while the last entry pops is taken straight from the AW bus.
    always_comb begin
        remaining = count - CW'(pop);
        head_load = pop | (push & (count == '0));
        head_next = '0;
        if (remaining != '0) begin
            head_next = mem[rd_ptr + PW'(1)];
        end else if (push) begin
            head_next = incoming;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= incoming;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axi_awready <= 1'b0;
            tx_wactive    <= 1'b0;
            head_q        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count         <= count_next;
            s_axi_awready <= (count_next < CW'(DEPTH));
            tx_wactive    <= (count_next != '0);
            if (head_load) begin
                head_q <= head_next;
            end
        end
    end

    assign tx_awid    = head_q.id;
    assign tx_awaddr  = head_q.addr;
    assign tx_awlen   = head_q.len;
    assign tx_awsize  = head_q.size;
    assign tx_awburst = head_q.burst;
    assign tx_slverr  = head_q.err;
    assign fifo_count = count;

endmodule

// File: tb/tb_axi_slave_aw_stage.sv
// Bench for axi_slave_aw_stage: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a queue-based model of the burst FIFO.
module tb_axi_slave_aw_stage;

    localparam int DEPTH  = 2;
    localparam int ID_W   = 12;
    localparam int ADDR_W = 32;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;
    } burst_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_axi_aresetn;
    logic               s_axi_awvalid;
    logic               s_axi_awready;
    logic [ID_W-1:0]    s_axi_awid;
    logic [ADDR_W-1:0]  s_axi_awaddr;
    logic [7:0]         s_axi_awlen;
    logic [2:0]         s_axi_awsize;
    logic [1:0]         s_axi_awburst;
    logic               tx_wactive;
    logic [ID_W-1:0]    tx_awid;
    logic [ADDR_W-1:0]  tx_awaddr;
    logic [7:0]         tx_awlen;
    logic [2:0]         tx_awsize;
    logic [1:0]         tx_awburst;
    logic               tx_slverr;
    logic               tx_done;
    logic [$clog2(DEPTH):0] fifo_count;

    int     n_checks = 0;
    int     n_fails  = 0;
    bit     checking_on = 1'b0;
    burst_t mq[$];
    logic   m_ready = 1'b0;

    axi_slave_aw_stage #(.DEPTH(DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .tx_wactive(tx_wactive), .tx_awid(tx_awid), .tx_awaddr(tx_awaddr),
        .tx_awlen(tx_awlen), .tx_awsize(tx_awsize), .tx_awburst(tx_awburst),
        .tx_slverr(tx_slverr), .tx_done(tx_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Legality from the burst rules in plain integer terms.
    function automatic logic model_err(logic [ADDR_W-1:0] addr, logic [7:0] len,
                                       logic [2:0] size, logic [1:0] burst);
        int beats = int'(len) + 1;
        int bytes;
        int offset = int'(addr % 4096);
        if (size > 2) return 1'b1;
        if (burst == 2'd3) return 1'b1;
        bytes = beats * (1 << size);
        if (burst == 2'd2) begin
            if (!(beats == 2 || beats == 4 || beats == 8 || beats == 16)) return 1'b1;
            if ((addr % (1 << size)) != 0) return 1'b1;
        end
        if (burst == 2'd1 && offset + bytes > 4096) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic nr, input logic v,
                                 input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic done);
        rst = r; s_axi_aresetn = nr; s_axi_awvalid = v; s_axi_awid = id;
        s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst; tx_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ordered list of accepted bursts, advanced at each active edge.
    always @(posedge clk) begin
        burst_t b;
        bit     do_push;
        bit     do_pop;
        if (rst || !s_axi_aresetn) begin
            mq.delete();
            m_ready = 1'b0;
        end else begin
            do_push = s_axi_awvalid && m_ready;
            do_pop  = tx_done && (mq.size() > 0);
            b.id = s_axi_awid; b.addr = s_axi_awaddr; b.len = s_axi_awlen;
            b.size = s_axi_awsize; b.burst = s_axi_awburst;
            b.err = model_err(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(b);
            m_ready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (checking_on) begin
            checkOutput("awready", 64'(s_axi_awready), 64'(m_ready));
            checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
            checkOutput("tx_wactive", 64'(tx_wactive), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                checkOutput("tx_awid", 64'(tx_awid), 64'(mq[0].id));
                checkOutput("tx_awaddr", 64'(tx_awaddr), 64'(mq[0].addr));
                checkOutput("tx_awlen", 64'(tx_awlen), 64'(mq[0].len));
                checkOutput("tx_awsize", 64'(tx_awsize), 64'(mq[0].size));
                checkOutput("tx_awburst", 64'(tx_awburst), 64'(mq[0].burst));
                checkOutput("tx_slverr", 64'(tx_slverr), 64'(mq[0].err));
            end
        end
    end

    task automatic pushThenPop(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic exp_err, input string name);
        applyStimulus(0, 1, 1, 12'h0A5, addr, len, size, burst, 0);
        tick();
        applyStimulus(0, 1, 0, 12'h0A5, addr, len, size, burst, 0);
        checkOutput({name, "_wactive"}, 64'(tx_wactive), 64'd1);
        checkOutput({name, "_slverr"}, 64'(tx_slverr), 64'(exp_err));
        checkOutput({name, "_addr"}, 64'(tx_awaddr), 64'(addr));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput({name, "_drained"}, 64'(fifo_count), 64'd0);
    endtask

    initial begin
        applyStimulus(1, 1, 0, '0, '0, '0, '0, '0, 0);
        tick();
        checking_on = 1'b1;
        tick();
        checkOutput("rst_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("rst_wactive", 64'(tx_wactive), 64'd0);
        checkOutput("rst_count", 64'(fifo_count), 64'd0);
        checkOutput("rst_addr", 64'(tx_awaddr), 64'd0);
        checkOutput("rst_slverr", 64'(tx_slverr), 64'd0);

        // Scenario 1: first burst after reset release
        applyStimulus(0, 1, 1, 12'h001, 32'h100, 8'd3, 3'd2, 2'd1, 0);
        tick();
        checkOutput("s1_awready", 64'(s_axi_awready), 64'd1);
        tick();
        s_axi_awvalid = 1'b0;
        checkOutput("s1_wactive", 64'(tx_wactive), 64'd1);
        checkOutput("s1_addr", 64'(tx_awaddr), 64'h100);
        checkOutput("s1_len", 64'(tx_awlen), 64'd3);
        checkOutput("s1_slverr", 64'(tx_slverr), 64'd0);

        // Scenario 2: fill to DEPTH, third burst held until a pop frees a slot
        applyStimulus(0, 1, 1, 12'h002, 32'h200, 8'd0, 3'd2, 2'd1, 0);
        tick();
        applyStimulus(0, 1, 1, 12'h003, 32'h300, 8'd0, 3'd2, 2'd1, 0);
        checkOutput("s2_full_count", 64'(fifo_count), 64'd2);
        checkOutput("s2_full_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("s2_head_hold", 64'(tx_awaddr), 64'h100);
        tick();
        checkOutput("s2_held_count", 64'(fifo_count), 64'd2);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("s2_pop_head", 64'(tx_awaddr), 64'h200);
        checkOutput("s2_pop_awready", 64'(s_axi_awready), 64'd1);
        checkOutput("s2_pop_count", 64'(fifo_count), 64'd1);
        tick();
        s_axi_awvalid = 1'b0;
        checkOutput("s2_third_count", 64'(fifo_count), 64'd2);
        checkOutput("s2_third_head", 64'(tx_awaddr), 64'h200);
        tx_done = 1'b1;
        tick();
        tick();
        tx_done = 1'b0;
        checkOutput("s2_drain", 64'(fifo_count), 64'd0);

        // Scenarios 3 and 4: legality boundaries
        pushThenPop(32'hFF0, 8'd3, 3'd2, 2'd1, 1'b0, "s3_4k_exact");
        pushThenPop(32'hFF4, 8'd3, 3'd2, 2'd1, 1'b1, "s3_4k_cross");
        pushThenPop(32'h000, 8'd2, 3'd2, 2'd2, 1'b1, "s4_wrap_len2");
        pushThenPop(32'h01C, 8'd7, 3'd2, 2'd2, 1'b0, "s4_wrap_len7");
        pushThenPop(32'h000, 8'd0, 3'd3, 2'd1, 1'b1, "s4_size3");
        pushThenPop(32'h000, 8'd0, 3'd2, 2'd3, 1'b1, "s4_rsvd");

        // Scenario 5: push and pop together with one entry queued
        applyStimulus(0, 1, 1, 12'h010, 32'h400, 8'd1, 3'd1, 2'd1, 0);
        tick();
        applyStimulus(0, 1, 1, 12'h011, 32'h500, 8'd1, 3'd1, 2'd1, 1);
        tick();
        applyStimulus(0, 1, 0, 12'h011, 32'h500, 8'd1, 3'd1, 2'd1, 0);
        checkOutput("s5_count", 64'(fifo_count), 64'd1);
        checkOutput("s5_head", 64'(tx_awaddr), 64'h500);
        checkOutput("s5_id", 64'(tx_awid), 64'h011);

        // Scenario 6: AXI reset with entries queued, then tx_done on an empty FIFO
        applyStimulus(0, 1, 1, 12'h012, 32'h600, 8'd0, 3'd0, 2'd0, 0);
        tick();
        s_axi_awvalid = 1'b0;
        checkOutput("s6_queued", 64'(fifo_count), 64'd2);
        s_axi_aresetn = 1'b0;
        tick();
        s_axi_aresetn = 1'b1;
        checkOutput("s6_count", 64'(fifo_count), 64'd0);
        checkOutput("s6_wactive", 64'(tx_wactive), 64'd0);
        checkOutput("s6_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("s6_addr", 64'(tx_awaddr), 64'd0);
        tick();
        checkOutput("s6_awready_after", 64'(s_axi_awready), 64'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checkOutput("s6_empty_done_count", 64'(fifo_count), 64'd0);
        checkOutput("s6_empty_done_ready", 64'(s_axi_awready), 64'd1);

        // Random traffic with boundary-biased fields and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic [ADDR_W-1:0] a;
            logic [7:0]        l;
            int                r;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
            l = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 16)) : 8'($urandom_range(0, 255));
            r = $urandom_range(0, 199);
            applyStimulus(r == 0, r != 1, $urandom_range(0, 9) < 6, 12'($urandom), a, l,
                          3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 4);
            tick();
        end
        applyStimulus(0, 1, 0, '0, '0, '0, '0, '0, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
